// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the nibble-serial ALU
//                sequencer (FSM states, nibble width, 74181 S/M codes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    // Width of one ALU slice
    localparam int NIBBLE_W = 4;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Named 74181 selection / mode pairs
    localparam logic [3:0] ADD_S    = 4'b1001;
    localparam logic       ADD_M    = 1'b0;
    localparam logic [3:0] SUB_S    = 4'b0110;
    localparam logic       SUB_M    = 1'b0;
    localparam logic [3:0] XOR_S    = 4'b0110;
    localparam logic       XOR_M    = 1'b1;
    localparam logic [3:0] PASS_A_S = 4'b1111;
    localparam logic       PASS_A_M = 1'b1;

endpackage : alu_seq_pkg

`default_nettype wire

// File: rtl/alu_nibble_sequencer.sv
// ============================================================================
//  Module      : alu_nibble_sequencer
//  Description : Runs a NIBBLES x 4-bit operation through one external
//                combinational 74181-style slice, LSB nibble first, one
//                nibble per cycle, and assembles the wide result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // request side
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [NIBBLES*4-1:0]      a_i,
    input  logic [NIBBLES*4-1:0]      b_i,
    input  logic [3:0]                sel_i,
    input  logic                      mode_i,
    input  logic                      carry_i,
    // ALU slice drive
    output logic [3:0]                alu_a_o,
    output logic [3:0]                alu_b_o,
    output logic [3:0]                alu_sel_o,
    output logic                      alu_mode_o,
    output logic                      alu_carry_o,
    // ALU slice return
    input  logic [3:0]                alu_f_i,
    input  logic                      alu_cout_i,
    input  logic                      alu_eq_i,
    // result side
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [NIBBLES*4-1:0]      result_o,
    output logic                      carry_o,
    output logic                      equal_o
);

    localparam int W     = NIBBLES * NIBBLE_W;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    seq_state_t          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [3:0]          r_sel;
    logic                r_mode;
    logic                r_cin;
    logic                r_carry;
    logic                r_eq;
    logic [W-1:0]        r_result;

    // Per-nibble views of the captured operands
    logic [NIBBLE_W-1:0] w_a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] w_b_nib [NIBBLES];

    for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
        assign w_a_nib[g] = r_a[g*NIBBLE_W +: NIBBLE_W];
        assign w_b_nib[g] = r_b[g*NIBBLE_W +: NIBBLE_W];
    end

    logic w_busy;
    logic w_done;

    assign w_busy = (r_state == ST_BUSY);
    assign w_done = (r_state == ST_DONE);

    // Handshake flags come straight from the state register
    assign in_ready_o  = (r_state == ST_IDLE);
    assign out_valid_o = w_done;

    // ALU drive is only non-zero while a nibble is in flight
    assign alu_a_o     = w_busy ? w_a_nib[r_idx] : '0;
    assign alu_b_o     = w_busy ? w_b_nib[r_idx] : '0;
    assign alu_sel_o   = w_busy ? r_sel          : '0;
    assign alu_mode_o  = w_busy & r_mode;
    assign alu_carry_o = w_busy & ((r_idx == '0) ? r_cin : r_carry);

    // Results are only exposed in DONE; carry is meaningless in logic mode
    assign result_o = w_done ? r_result : '0;
    assign carry_o  = w_done & ~r_mode & r_carry;
    assign equal_o  = w_done & r_eq;

    // Sequencer FSM: accept, step through nibbles, hold result until taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_mode   <= 1'b0;
            r_cin    <= 1'b0;
            r_carry  <= 1'b0;
            r_eq     <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_a      <= a_i;
                        r_b      <= b_i;
                        r_sel    <= sel_i;
                        r_mode   <= mode_i;
                        r_cin    <= carry_i;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_carry  <= 1'b0;
                        r_eq     <= 1'b1;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_result[k*NIBBLE_W +: NIBBLE_W] <= alu_f_i;
                        end
                    end
                    r_carry <= alu_cout_i;
                    r_eq    <= r_eq & alu_eq_i;
                    // Index holds at the last nibble instead of wrapping
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : alu_nibble_sequencer

`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
// ============================================================================
//  Module      : tb_alu_nibble_sequencer
//  Description : Directed bench for alu_nibble_sequencer with a behavioural
//                74181-style slice (active-high data and carry).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_nibble_sequencer;
    import alu_seq_pkg::*;

    localparam int NIB = 4;
    localparam int W   = NIB * 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    sel = '0;
    logic          mode = 1'b0;
    logic          cin = 1'b0;
    logic [3:0]    alu_a, alu_b, alu_sel;
    logic          alu_mode, alu_carry;
    logic [3:0]    alu_f;
    logic          alu_cout, alu_eq;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          equal;

    int vectors     = 0;
    int miscompares = 0;

    // Captured by run_op
    logic [W-1:0]  got_res;
    logic          got_c;
    logic          got_eq;
    int            got_lat;
    logic [3:0]    got_cy;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .sel_i       (sel),
        .mode_i      (mode),
        .carry_i     (cin),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_sel_o   (alu_sel),
        .alu_mode_o  (alu_mode),
        .alu_carry_o (alu_carry),
        .alu_f_i     (alu_f),
        .alu_cout_i  (alu_cout),
        .alu_eq_i    (alu_eq),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .carry_o     (carry_out),
        .equal_o     (equal)
    );

    // Behavioural slice: carry chain from the arithmetic form of S, F from M
    logic [3:0] bop;
    logic [4:0] sum;
    always_comb begin
        bop = alu_b;
        case (alu_sel)
            4'b1001: bop = alu_b;
            4'b0110: bop = ~alu_b;
            4'b1111: bop = 4'hF;
            default: bop = alu_b;
        endcase
        sum = {1'b0, alu_a} + {1'b0, bop} + {4'b0, alu_carry};
        if (alu_mode) begin
            case (alu_sel)
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b1111: alu_f = alu_a;
                default: alu_f = alu_a ^ alu_b;
            endcase
        end else begin
            alu_f = sum[3:0];
        end
        alu_cout = sum[4];
        alu_eq   = (alu_f == 4'hF);
    end

    // Issue one request, measure latency, log per-nibble carry in, take result
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [3:0] ts, input logic tm, input logic tc);
        a = ta; b = tb; sel = ts; mode = tm; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = '1; b = '1; sel = 4'h0; mode = ~tm; cin = ~tc;
        got_lat = 0;
        got_cy  = '0;
        while (!out_valid && got_lat < 20) begin
            if (got_lat < 4) got_cy[got_lat] = alu_carry;
            @(posedge clk); #1;
            got_lat++;
        end
        got_res = result;
        got_c   = carry_out;
        got_eq  = equal;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_hs: got ready/valid=%b need 10", {in_ready, out_valid});
        end
        vectors++;
        if ({result, carry_out, equal, alu_a, alu_b, alu_sel, alu_mode, alu_carry} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got result=%h c=%b eq=%b alu_a=%h need all 0",
                     result, carry_out, equal, alu_a);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        run_op(16'h1234, 16'h0FFF, ADD_S, ADD_M, 1'b0);
        vectors++;
        if (got_res !== 16'h2233 || got_c !== 1'b0 || got_eq !== 1'b0) begin
            miscompares++;
            $display("FAIL add: got %h c=%b eq=%b need 2233 c=0 eq=0", got_res, got_c, got_eq);
        end
        vectors++;
        if (got_lat !== 4) begin
            miscompares++;
            $display("FAIL add_latency: got %0d need 4", got_lat);
        end
    endtask

    task automatic test_add_overflow();
        run_op(16'hFFFF, 16'h0001, ADD_S, ADD_M, 1'b0);
        vectors++;
        if (got_res !== 16'h0000 || got_c !== 1'b1) begin
            miscompares++;
            $display("FAIL add_ovf: got %h c=%b need 0000 c=1", got_res, got_c);
        end
        vectors++;
        if (got_cy !== 4'b1110) begin
            miscompares++;
            $display("FAIL add_ovf_chain: got carry-in per nibble %b need 1110", got_cy);
        end
    endtask

    task automatic test_xor();
        run_op(16'hA5A5, 16'hFFFF, XOR_S, XOR_M, 1'b0);
        vectors++;
        if (got_res !== 16'h5A5A || got_c !== 1'b0) begin
            miscompares++;
            $display("FAIL xor: got %h c=%b need 5A5A c=0", got_res, got_c);
        end
    endtask

    task automatic test_logic_carry_masked();
        // Chain carries on every nibble yet carry_o must read 0
        run_op(16'hFFFF, 16'h1234, PASS_A_S, PASS_A_M, 1'b1);
        vectors++;
        if (got_res !== 16'hFFFF || got_c !== 1'b0 || got_eq !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_a: got %h c=%b eq=%b need FFFF c=0 eq=1", got_res, got_c, got_eq);
        end
        vectors++;
        if (got_cy !== 4'b1111) begin
            miscompares++;
            $display("FAIL pass_a_chain: got carry-in per nibble %b need 1111", got_cy);
        end
    endtask

    task automatic test_equality();
        run_op(16'h3C3C, 16'h3C3C, SUB_S, SUB_M, 1'b0);
        vectors++;
        if (got_res !== 16'hFFFF || got_eq !== 1'b1 || got_c !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_eq: got %h eq=%b c=%b need FFFF eq=1 c=0", got_res, got_eq, got_c);
        end
        run_op(16'h3C3C, 16'h3C3D, SUB_S, SUB_M, 1'b0);
        vectors++;
        if (got_res !== 16'hFFFE || got_eq !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_ne: got %h eq=%b need FFFE eq=0", got_res, got_eq);
        end
    endtask

    task automatic test_backpressure();
        int waited;
        a = 16'h1234; b = 16'h0FFF; sel = ADD_S; mode = ADD_M; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        vectors++;
        if (!out_valid) begin
            miscompares++;
            $display("FAIL bp_timeout: got out_valid=0 need 1");
        end
        // Competing request with different operands while result is held
        a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (result !== 16'h2233 || out_valid !== 1'b1 || in_ready !== 1'b0 || carry_out !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got res=%h v=%b r=%b c=%b need 2233 v=1 r=0 c=0",
                         i, result, out_valid, in_ready, carry_out);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10 || result !== '0) begin
            miscompares++;
            $display("FAIL bp_release: got r/v=%b res=%h need 10 res=0", {in_ready, out_valid}, result);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ignored: got out_valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_reset_busy();
        a = 16'h1234; b = 16'h0FFF; sel = ADD_S; mode = ADD_M; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (alu_a !== 4'h2 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rb_nibble2: got alu_a=%h ready=%b need 2 ready=0", alu_a, in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10 ||
            {result, carry_out, equal, alu_a, alu_b, alu_sel, alu_mode, alu_carry} !== '0) begin
            miscompares++;
            $display("FAIL rb_after: got r/v=%b res=%h alu_a=%h alu_c=%b need 10 and zeros",
                     {in_ready, out_valid}, result, alu_a, alu_carry);
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rb_discard: got out_valid=%b need 0", out_valid);
        end
        run_op(16'h0001, 16'h0001, ADD_S, ADD_M, 1'b0);
        vectors++;
        if (got_res !== 16'h0002 || got_c !== 1'b0 || got_lat !== 4) begin
            miscompares++;
            $display("FAIL rb_next: got %h c=%b lat=%0d need 0002 c=0 lat=4", got_res, got_c, got_lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_overflow();
        test_xor();
        test_logic_carry_masked();
        test_equality();
        test_backpressure();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_nibble_sequencer

`default_nettype wire

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Multi-cycle sequencer that runs NIBBLES×4-bit operations through a single 4-bit 74181-style ALU slice, one nibble per cycle, LSB nibble first. Sits directly upstream of the ALU slice and drives its operand, select, mode and carry inputs. Also sits directly downstream of it: it consumes F, carry-out and equality and assembles the wide result. A valid/ready handshake connects it to the datapath controller on both sides.

## Interface
- NIBBLES, default 4: number of 4-bit slices per operation; data width W = 4*NIBBLES; legal range 1..8.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  operation request valid.
- in_ready_o  output  1  sequencer can accept a request.
- a_i, b_i  input  W  operands.
- sel_i  input  4  ALU S selection code.
- mode_i  input  1  ALU M input: 1 = logic, 0 = arithmetic.
- carry_i  input  1  active-high carry into nibble 0.
- alu_a_o, alu_b_o  output  4  current nibble of A and B to the ALU slice.
- alu_sel_o  output  4  S to the ALU slice.
- alu_mode_o  output  1  M to the ALU slice.
- alu_carry_o  output  1  carry into the ALU slice for the current nibble.
- alu_f_i  input  4  F from the ALU slice.
- alu_cout_i  input  1  carry-out from the ALU slice (active-high).
- alu_eq_i  input  1  equality output from the ALU slice.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- result_o  output  W  assembled F.
- carry_o  output  1  final carry-out; forced 0 in logic mode.
- equal_o  output  1  AND of alu_eq_i over all nibbles.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready_o = 1.
  - When in_valid_i is high, the sequencer registers a_i, b_i, sel_i, mode_i and carry_i.
  - It then clears the nibble index and the result registers, sets the equality accumulator to 1, and goes to BUSY.
- BUSY, nibble index i from 0 to NIBBLES-1:
  - alu_a_o and alu_b_o carry bits [4i+3:4i] of the captured A and B.
  - alu_sel_o and alu_mode_o carry the captured S and M.
  - alu_carry_o is the captured carry when i = 0, and the registered carry when i > 0.
  - At the end of each cycle: result[4i+3:4i] <= alu_f_i, carry register <= alu_cout_i, equality accumulator &= alu_eq_i, i <= i+1.
  - After nibble NIBBLES-1, the FSM goes to DONE.
- DONE:
  - out_valid_o = 1.
  - result_o, carry_o and equal_o hold stable until out_ready_i is high.
  - On handshake, the FSM goes to IDLE.
- Logic mode (M = 1): the carry chain is still driven, but carry_o is reported as 0.
- Operands are captured at accept, so a_i, b_i and the other request inputs may change freely while BUSY or DONE.
- in_ready_o is 0 in BUSY and DONE. Requests never overlap.
- ALU drive outputs are 0 in IDLE and DONE.
- result_o, carry_o and equal_o read as 0 outside DONE.
- No wrap-around handling: the index saturates, because BUSY exits at NIBBLES-1.

## Timing
- Reset, in any state including mid-BUSY:
  - Next cycle: IDLE; in_ready_o = 1; out_valid_o = 0; all data and ALU outputs = 0.
  - The in-flight operation is discarded and is not reported.
- Latency: out_valid_o rises exactly NIBBLES cycles after the accepting edge.
- Throughput: at most one operation per NIBBLES+2 cycles (accept, NIBBLES BUSY cycles, DONE, IDLE).
- The ALU slice is combinational. alu_f_i, alu_cout_i and alu_eq_i are sampled in the same cycle their inputs are driven; this is a single-cycle path through the slice.
- rst_i has priority over any handshake occurring in the same cycle.

## Structure
- Shared package alu_seq_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - NIBBLE_W = 4;
  - named S/M constants: ADD = S 1001 with M 0; SUB = S 0110 with M 0; XOR = S 0110 with M 1; PASS_A = S 1111 with M 1.
- No sub-module inside this block. The ALU slice is instantiated alongside it at the next level up and wired port to port.

## Test plan
All scenarios use NIBBLES = 4 with the 74181 slice connected.
- ADD, carry 0: A = 0x1234, B = 0x0FFF -> result 0x2233, carry_o 0, out_valid 4 cycles after accept.
- ADD overflow: A = 0xFFFF, B = 0x0001, carry 0 -> result 0x0000, carry_o 1. alu_carry_o is 1 on nibbles 1..3.
- XOR logic: A = 0xA5A5, B = 0xFFFF -> result 0x5A5A, carry_o 0.
- Equality: SUB, carry 0, A = B = 0x3C3C -> result 0xFFFF, equal_o 1. Repeat with B = 0x3C3D -> equal_o 0.
- Backpressure: hold out_ready_i low for 5 cycles in DONE -> outputs stable, in_ready_o 0, a new in_valid_i is ignored.
- Reset during BUSY at nibble 2 -> next cycle IDLE, all outputs 0. A following ADD 0x0001 + 0x0001 completes with result 0x0002.
